// File: rtl/alsu_rr_scheduler.sv
// alsu_rr_scheduler: shares one ALSU among N requesters with round-robin grants,
// tracks the ALSU latency with a tag pipeline and returns results through a
// credit-protected FIFO. Define ALSU_SCHED_LOCK_EN to add the req_lock port.
module alsu_rr_scheduler #(
  parameter int N          = 4,
  parameter int WIDTH      = 3,
  parameter int OUT_W      = 6,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [N-1:0]                           req_valid,
  output logic [N-1:0]                           req_ready,
  input  logic [3*N-1:0]                         req_opcode,
  input  logic [WIDTH*N-1:0]                     req_A,
  input  logic [WIDTH*N-1:0]                     req_B,
  input  logic [N-1:0]                           req_cin,
  input  logic [N-1:0]                           req_serial_in,
  input  logic [N-1:0]                           req_direction,
  input  logic [N-1:0]                           req_red_op_A,
  input  logic [N-1:0]                           req_red_op_B,
  input  logic [N-1:0]                           req_bypass_A,
  input  logic [N-1:0]                           req_bypass_B,
  output logic [2:0]                             alsu_opcode,
  output logic [WIDTH-1:0]                       alsu_A,
  output logic [WIDTH-1:0]                       alsu_B,
  output logic                                   alsu_cin,
  output logic                                   alsu_serial_in,
  output logic                                   alsu_direction,
  output logic                                   alsu_red_op_A,
  output logic                                   alsu_red_op_B,
  output logic                                   alsu_bypass_A,
  output logic                                   alsu_bypass_B,
  input  logic [OUT_W-1:0]                       alsu_out,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]   rsp_id,
  output logic [OUT_W-1:0]                       rsp_data,
  output logic                                   rsp_err
`ifdef ALSU_SCHED_LOCK_EN
  ,
  input  logic [N-1:0]                           req_lock
`endif
);

  localparam int ID_W = (N > 1) ? $clog2(N) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW   = ID_W + OUT_W + 1;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] start;
  logic [ID_W-1:0] grant_id;
  logic [N-1:0]    grant;
  logic [CW-1:0]   credits;
  logic            accept;
  logic            pop;
  logic            push;
  logic            grant_err;

  logic [LAT-1:0]  tag_v;
  logic [ID_W-1:0] tag_id  [LAT];
  logic            tag_err [LAT];

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] x);
    if (int'(x) == N - 1) return '0;
    return x + 1'b1;
  endfunction

  function automatic logic [PW-1:0] next_slot(input logic [PW-1:0] x);
    if (int'(x) == FIFO_DEPTH - 1) return '0;
    return x + 1'b1;
  endfunction

`ifdef ALSU_SCHED_LOCK_EN
  logic            lock_active;
  logic [ID_W-1:0] lock_owner;
  logic            owner_hold;

  // A lock that has lost its owner's valid already searches from owner+1
  assign owner_hold = lock_active & req_valid[lock_owner];
  assign start      = lock_active ? next_id(lock_owner) : ptr;
`else
  assign start = ptr;
`endif

  // Round-robin search from the start pointer; lowest offset wins
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    grant_id = '0;
    if (!reset && credits != '0) begin
`ifdef ALSU_SCHED_LOCK_EN
      if (owner_hold) begin
        grant[lock_owner] = 1'b1;
        grant_id          = lock_owner;
      end else
`endif
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(start) + k;
        if (idx >= N) idx = idx - N;
        if (req_valid[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
          grant_id   = ID_W'(idx);
        end
      end
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;

  // Route the granted payload to the ALSU, otherwise hold it on a NOP
  always_comb begin
    int sel;
    sel            = int'(grant_id);
    alsu_opcode    = 3'd0;
    alsu_A         = '0;
    alsu_B         = '0;
    alsu_cin       = 1'b0;
    alsu_serial_in = 1'b0;
    alsu_direction = 1'b0;
    alsu_red_op_A  = 1'b0;
    alsu_red_op_B  = 1'b0;
    alsu_bypass_A  = 1'b1;
    alsu_bypass_B  = 1'b1;
    if (accept) begin
      alsu_opcode    = req_opcode[3*sel +: 3];
      alsu_A         = req_A[WIDTH*sel +: WIDTH];
      alsu_B         = req_B[WIDTH*sel +: WIDTH];
      alsu_cin       = req_cin[sel];
      alsu_serial_in = req_serial_in[sel];
      alsu_direction = req_direction[sel];
      alsu_red_op_A  = req_red_op_A[sel];
      alsu_red_op_B  = req_red_op_B[sel];
      alsu_bypass_A  = req_bypass_A[sel];
      alsu_bypass_B  = req_bypass_B[sel];
    end
  end

  assign grant_err = (alsu_opcode[2:1] == 2'b11) |
                     ((alsu_red_op_A | alsu_red_op_B) & (alsu_opcode >= 3'd2));

  // Pointer advances past the served requester unless it keeps a lock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
`ifdef ALSU_SCHED_LOCK_EN
      lock_active <= 1'b0;
      lock_owner  <= '0;
`endif
    end else begin
      if (accept) begin
`ifdef ALSU_SCHED_LOCK_EN
        if (req_lock[grant_id]) begin
          lock_active <= 1'b1;
          lock_owner  <= grant_id;
        end else begin
          lock_active <= 1'b0;
          ptr         <= next_id(grant_id);
        end
`else
        ptr <= next_id(grant_id);
`endif
      end
`ifdef ALSU_SCHED_LOCK_EN
      else if (lock_active && !req_valid[lock_owner]) begin
        lock_active <= 1'b0;
        ptr         <= next_id(lock_owner);
      end
`endif
    end
  end

  // One credit per FIFO slot: taken on issue, returned when the result leaves
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits <= CW'(FIFO_DEPTH);
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Tag pipeline mirrors the ALSU latency so each result meets its owner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v <= '0;
      for (int k = 0; k < LAT; k++) begin
        tag_id[k]  <= '0;
        tag_err[k] <= 1'b0;
      end
    end else begin
      tag_v[0]   <= accept;
      tag_id[0]  <= grant_id;
      tag_err[0] <= grant_err;
      for (int k = 1; k < LAT; k++) begin
        tag_v[k]   <= tag_v[k-1];
        tag_id[k]  <= tag_id[k-1];
        tag_err[k] <= tag_err[k-1];
      end
    end
  end

  assign push = tag_v[LAT-1];

  // Result storage; entries are only meaningful while counted as occupied
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tag_id[LAT-1], alsu_out, tag_err[LAT-1]};
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_slot(wr_ptr);
      if (pop)  rd_ptr <= next_slot(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign {rsp_id, rsp_data, rsp_err} = rsp_valid ? mem[rd_ptr] : '0;

endmodule
